// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage word RAM with fixed wait states, pipeline stall and illegal-request flag
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        Stall,
    output logic        Done,
    output logic [31:0] ReadData,
    output logic        Err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;
    logic [31:0] mem [DEPTH_WORDS];
    logic [3:0] cnt;
    logic [AW-1:0] idx;
    logic [31:0] wdata;
    logic op_wr;
    logic ill;
    logic req;
    logic go;
    logic unused_addr;
    assign unused_addr = &{1'b0, Addr[31:AW+2]};
    assign req = MemRead | MemWrite;
    assign go = state == BUSY && cnt == 4'd0;
    assign Stall = state == IDLE ? req : state == BUSY;
    assign Done = state == DONE;
    assign Err = Done & ill;
    always_ff @(posedge clk)
        if (!reset && go && op_wr && !ill) mem[idx] <= wdata;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            ReadData <= '0;
            ill      <= 1'b0;
            op_wr    <= 1'b0;
            idx      <= '0;
            wdata    <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    op_wr <= MemWrite;
                    idx   <= Addr[2 +: AW];
                    wdata <= WriteData;
                    ill   <= (MemRead & MemWrite) | (|Addr[1:0]);
                    cnt   <= 4'(WAIT_CYCLES);
                    state <= BUSY;
                end
                BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else begin
                    // illegal requests of either kind clear ReadData; legal stores leave it alone
                    if (ill) ReadData <= '0;
                    else if (!op_wr) ReadData <= mem[idx];
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: scoreboard bench for two responders, WAIT_CYCLES=2 (d=0) and WAIT_CYCLES=0 (d=1)
module tb_dmem_responder;
    typedef struct {
        logic        err;
        logic        chk;
        logic [31:0] rd;
    } exp_t;
    logic        clk = 0;
    logic        reset = 0;
    logic        rd_i [2];
    logic        wr_i [2];
    logic [31:0] addr [2];
    logic [31:0] wdat [2];
    logic        stall [2];
    logic        done [2];
    logic        err [2];
    logic [31:0] rdata [2];
    exp_t q[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_done = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .reset(reset), .MemRead(rd_i[0]), .MemWrite(wr_i[0]), .Addr(addr[0]),
        .WriteData(wdat[0]), .Stall(stall[0]), .Done(done[0]), .ReadData(rdata[0]), .Err(err[0])
    );
    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .reset(reset), .MemRead(rd_i[1]), .MemWrite(wr_i[1]), .Addr(addr[1]),
        .WriteData(wdat[1]), .Stall(stall[1]), .Done(done[1]), .ReadData(rdata[1]), .Err(err[1])
    );

    task automatic access(input int d, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic err_e, input logic chk, input logic [31:0] rd_e);
        exp_t e;
        int n;
        n = d == 0 ? 2 : 0;
        @(negedge clk);
        rd_i[d] = r;
        wr_i[d] = w;
        addr[d] = a;
        wdat[d] = wd;
        q.push_back('{err_e, chk, rd_e});
        #1;
        checks++;
        if (stall[d] !== 1'b1) begin
            errors++;
            $display("FAIL stall_first d=%0d a=%h got=%b want=1", d, a, stall[d]);
        end
        for (int k = 1; k <= n + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                rd_i[d] = 0;
                wr_i[d] = 0;
            end
            #1;
            checks++;
            if (stall[d] !== 1'b1 || done[d] !== 1'b0) begin
                errors++;
                $display("FAIL busy d=%0d a=%h k=%0d got stall=%b done=%b want stall=1 done=0", d, a, k, stall[d], done[d]);
            end
        end
        @(negedge clk);
        #1;
        last_done = cyc;
        checks++;
        if (done[d] !== 1'b1 || stall[d] !== 1'b0) begin
            errors++;
            $display("FAIL done d=%0d a=%h got done=%b stall=%b want done=1 stall=0", d, a, done[d], stall[d]);
        end
        e = q.pop_front();
        checks++;
        if (err[d] !== e.err) begin
            errors++;
            $display("FAIL err d=%0d a=%h got=%b want=%b", d, a, err[d], e.err);
        end
        if (e.chk) begin
            checks++;
            if (rdata[d] !== e.rd) begin
                errors++;
                $display("FAIL rdata d=%0d a=%h got=%h want=%h", d, a, rdata[d], e.rd);
            end
        end
    endtask

    task automatic test_reset;
        for (int d = 0; d < 2; d++) begin
            rd_i[d] = 0;
            wr_i[d] = 0;
            addr[d] = 0;
            wdat[d] = 0;
        end
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (stall[d] !== 1'b0 || done[d] !== 1'b0 || err[d] !== 1'b0 || rdata[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset d=%0d got stall=%b done=%b err=%b rdata=%h want 0", d, stall[d], done[d], err[d], rdata[d]);
            end
        end
    endtask

    task automatic test_write_read;
        access(0, 0, 1, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0);
        access(0, 1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF);
        access(0, 0, 1, 32'h20, 32'h0BADF00D, 0, 1, 32'hDEADBEEF);
    endtask

    task automatic test_back_to_back;
        int first;
        access(1, 0, 1, 32'h4, 32'h12345678, 0, 0, 32'h0);
        first = last_done;
        access(1, 1, 0, 32'h4, 32'h0, 0, 1, 32'h12345678);
        checks++;
        if (last_done - first !== 3) begin
            errors++;
            $display("FAIL spacing got=%0d want=3", last_done - first);
        end
    endtask

    task automatic test_illegal;
        access(0, 1, 0, 32'h6, 32'h0, 1, 1, 32'h0);
        access(0, 0, 1, 32'h8, 32'h55AA55AA, 0, 0, 32'h0);
        access(0, 1, 1, 32'h8, 32'hFFFFFFFF, 1, 0, 32'h0);
        access(0, 1, 0, 32'h8, 32'h0, 0, 1, 32'h55AA55AA);
    endtask

    task automatic test_wrap;
        access(0, 0, 1, 32'h400, 32'hA5A5A5A5, 0, 0, 32'h0);
        access(0, 1, 0, 32'h0, 32'h0, 0, 1, 32'hA5A5A5A5);
    endtask

    task automatic test_reset_mid;
        access(0, 0, 1, 32'hC, 32'h11111111, 0, 0, 32'h0);
        @(negedge clk);
        wr_i[0] = 1;
        addr[0] = 32'hC;
        wdat[0] = 32'h22222222;
        @(negedge clk);
        wr_i[0] = 0;
        reset = 1;
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (stall[0] !== 1'b0 || done[0] !== 1'b0 || rdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid got stall=%b done=%b rdata=%h want 0 0 0", stall[0], done[0], rdata[0]);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (done[0] !== 1'b0) begin
                errors++;
                $display("FAIL reset_nodone k=%0d got=%b want=0", k, done[0]);
            end
        end
        access(0, 1, 0, 32'hC, 32'h0, 0, 1, 32'h11111111);
    endtask

    task automatic test_held;
        exp_t e;
        @(negedge clk);
        rd_i[0] = 1;
        addr[0] = 32'h10;
        for (int i = 0; i < 3; i++) q.push_back('{1'b0, 1'b1, 32'hDEADBEEF});
        for (int k = 0; k < 15; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            checks++;
            if (stall[0] !== (k % 5 != 4) || done[0] !== (k % 5 == 4)) begin
                errors++;
                $display("FAIL held k=%0d got stall=%b done=%b want stall=%b done=%b", k, stall[0], done[0], k % 5 != 4, k % 5 == 4);
            end
            if (done[0] === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL held_extra k=%0d got done=1 want no pending", k);
                end else begin
                    e = q.pop_front();
                    if (rdata[0] !== e.rd || err[0] !== e.err) begin
                        errors++;
                        $display("FAIL held_data k=%0d got rdata=%h err=%b want %h %b", k, rdata[0], err[0], e.rd, e.err);
                    end
                end
            end
        end
        @(negedge clk);
        rd_i[0] = 0;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL held_missing got pending=%0d want 0", q.size());
        end
        q.delete();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_back_to_back;
        test_illegal;
        test_wrap;
        test_reset_mid;
        test_held;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
